// File: rtl/key_loader_pkg.sv
// key_loader_pkg: shared constants and state encoding for the PBKDF2 key loader.
//   KEY_BYTES  - key capacity in bytes (one SHA-512 HMAC block)
//   KEY_BITS   - assembled key width
//   KEY_LEN_W  - width of the stored-byte count (holds 0..128)
//   loader_state_e - ACCEPT (collecting bytes), DRAIN (discarding overlong
//                    tail), HOLD (key presented until acknowledged)
package key_loader_pkg;

    localparam int KEY_BYTES = 128;
    localparam int KEY_BITS  = 8 * KEY_BYTES;
    localparam int KEY_LEN_W = 8;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        DRAIN  = 2'd1,
        HOLD   = 2'd2
    } loader_state_e;

endpackage

// File: rtl/key_loader.sv
// key_loader: assembles a byte-streamed password MSB-first into a 1024-bit
// zero-padded HMAC key and holds it until the consumer acknowledges it.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   in_valid   - password byte beat valid
//   in_ready   - loader can accept a beat (low only while holding a key)
//   in_data    - password byte
//   in_last    - beat carries the final password byte
//   key        - assembled key, byte k at [1023-8k -: 8], unused bytes zero
//   key_len    - number of stored bytes, saturates at 128
//   key_valid  - key complete and stable
//   key_err    - password was longer than 128 bytes (key truncated)
//   key_ack    - consumer done with key; clears and re-arms the loader
module key_loader
    import key_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    input  logic                 in_last,
    output logic [KEY_BITS-1:0]  key,
    output logic [KEY_LEN_W-1:0] key_len,
    output logic                 key_valid,
    output logic                 key_err,
    input  logic                 key_ack
);

    loader_state_e        state_r;
    loader_state_e        state_next_s;
    logic [KEY_BITS-1:0]  key_r;
    logic [KEY_LEN_W-1:0] count_r;
    logic                 err_r;

    logic                 accept_s;
    logic                 wr_en_s;
    logic                 set_err_s;
    logic                 clr_s;
    logic [9:0]           slot_lsb_s;

    // Handshake: the loader stalls input only while presenting a key.
    assign accept_s = in_valid && (state_r != HOLD);

    // Byte slot k occupies key[1023-8k -: 8]; this is its low bit index.
    // Only used while count < 128, so the 7-bit slot number suffices.
    assign slot_lsb_s = 10'd1016 - {count_r[6:0], 3'b000};

    // Next-state and datapath control decode.
    always_comb begin
        state_next_s = state_r;
        wr_en_s      = 1'b0;
        set_err_s    = 1'b0;
        clr_s        = 1'b0;
        case (state_r)
            ACCEPT: begin
                if (accept_s) begin
                    if (count_r < 8'd128) begin
                        wr_en_s = 1'b1;
                        if (in_last) begin
                            state_next_s = HOLD;
                        end else begin
                            state_next_s = ACCEPT;
                        end
                    end else begin
                        // Overlong: drop the byte, flag, and skip the rest.
                        set_err_s = 1'b1;
                        if (in_last) begin
                            state_next_s = HOLD;
                        end else begin
                            state_next_s = DRAIN;
                        end
                    end
                end else begin
                    state_next_s = ACCEPT;
                end
            end
            DRAIN: begin
                if (accept_s && in_last) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            HOLD: begin
                if (key_ack) begin
                    clr_s        = 1'b1;
                    state_next_s = ACCEPT;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = ACCEPT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ACCEPT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Key storage, byte count and overlong flag; cleared on ack so the
    // next password starts from an all-zero (padded) key.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_r   <= {KEY_BITS{1'b0}};
            count_r <= 8'd0;
            err_r   <= 1'b0;
        end else if (clr_s) begin
            key_r   <= {KEY_BITS{1'b0}};
            count_r <= 8'd0;
            err_r   <= 1'b0;
        end else begin
            if (wr_en_s) begin
                key_r[slot_lsb_s +: 8] <= in_data;
                count_r                <= count_r + 8'd1;
            end
            if (set_err_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Outputs come straight from registers or from a decode of the state
    // register, so nothing combinational from in_valid/key_ack reaches them.
    assign in_ready  = (state_r != HOLD);
    assign key_valid = (state_r == HOLD);
    assign key       = key_r;
    assign key_len   = count_r;
    assign key_err   = err_r;

endmodule
